// File: rtl/ct_ciu_bar_bcast_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ct_ciu_bar_bcast_ctrl
// Description : CIU barrier broadcast controller. Round-robin selects one PIU
//               barrier, broadcasts it to snb0/snb1/ncq/ctcq, collects grants
//               and pulses done back to the owner. Optional watchdog enabled
//               by defining CT_CIU_BAR_TMO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_ciu_bar_bcast_ctrl #(
    parameter int TMO_W = 10
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic [3:0]  piu_bar_req,
    input  logic [35:0] piu_bar_req_bus,
    input  logic [3:0]  tgt_bar_grant,
    output logic [3:0]  tgt_bar_req,
    output logic [2:0]  tgt_bar_mid,
    output logic [8:0]  tgt_bar_req_bus,
    output logic [3:0]  piu_bar_done,
    output logic        bar_busy,
    output logic        bar_tmo_err
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BCAST = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_gnt;
    logic [1:0] r_mid;
    logic [8:0] r_bus;
    logic [1:0] r_rr_ptr;
    logic       w_win_vld;
    logic [1:0] w_win_idx;
    logic [3:0] w_acc;

    // Scan from the highest offset down so the offset nearest rr_ptr wins.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (piu_bar_req[r_rr_ptr + 2'(i)]) begin
                w_win_vld = 1'b1;
                w_win_idx = r_rr_ptr + 2'(i);
            end
        end
    end

    assign w_acc = tgt_bar_grant & tgt_bar_req;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_win_vld) w_state_nxt = c_ST_BCAST;
            c_ST_BCAST: if ((r_gnt | w_acc) == 4'b1111) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state  <= c_ST_IDLE;
            r_gnt    <= 4'b0000;
            r_mid    <= 2'd0;
            r_bus    <= 9'd0;
            r_rr_ptr <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_win_vld) begin
                        r_mid <= w_win_idx;
                        r_bus <= piu_bar_req_bus[9*w_win_idx +: 9];
                        r_gnt <= 4'b0000;
                    end
                end
                c_ST_BCAST: r_gnt    <= r_gnt | w_acc;
                c_ST_DONE:  r_rr_ptr <= r_mid + 2'd1;
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; grants never reach an output combinationally.
    assign bar_busy        = (r_state != c_ST_IDLE);
    assign tgt_bar_req     = (r_state == c_ST_BCAST) ? ~r_gnt : 4'b0000;
    assign tgt_bar_mid     = bar_busy ? {1'b0, r_mid} : 3'd0;
    assign tgt_bar_req_bus = bar_busy ? r_bus : 9'd0;
    assign piu_bar_done    = (r_state == c_ST_DONE) ? (4'b0001 << r_mid) : 4'b0000;

`ifdef CT_CIU_BAR_TMO_EN
    localparam logic [TMO_W-1:0] c_TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_err;
    logic             w_tmo_inc;

    assign w_tmo_inc = (r_state == c_ST_BCAST) && (w_acc == 4'b0000) && (r_tmo_cnt != '1);

    // Error is flagged on the same edge the counter saturates; the barrier keeps waiting.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if ((r_state == c_ST_IDLE) && w_win_vld) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == c_ST_BCAST) && (w_acc != 4'b0000)) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_inc && (r_tmo_cnt == c_TMO_LAST)) begin
                r_tmo_err <= 1'b1;
            end
        end
    end

    assign bar_tmo_err = r_tmo_err;
`else
    assign bar_tmo_err = 1'b0 & (TMO_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ct_ciu_bar_bcast_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_ciu_bar_bcast_ctrl
// Description : Directed bench for ct_ciu_bar_bcast_ctrl with a transaction
//               level reference model and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_ciu_bar_bcast_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic [3:0]  piu_bar_req;
    logic [35:0] piu_bar_req_bus;
    logic [3:0]  tgt_bar_grant;
    logic [3:0]  tgt_bar_req;
    logic [2:0]  tgt_bar_mid;
    logic [8:0]  tgt_bar_req_bus;
    logic [3:0]  piu_bar_done;
    logic        bar_busy;
    logic        bar_tmo_err;

    always #5 clk = ~clk;

    ct_ciu_bar_bcast_ctrl dut (
        .forever_cpuclk  (clk),
        .cpurst          (cpurst),
        .piu_bar_req     (piu_bar_req),
        .piu_bar_req_bus (piu_bar_req_bus),
        .tgt_bar_grant   (tgt_bar_grant),
        .tgt_bar_req     (tgt_bar_req),
        .tgt_bar_mid     (tgt_bar_mid),
        .tgt_bar_req_bus (tgt_bar_req_bus),
        .piu_bar_done    (piu_bar_done),
        .bar_busy        (bar_busy),
        .bar_tmo_err     (bar_tmo_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = broadcasting (m_pend = targets still owed), 2 = done.
    int         m_phase;
    logic [3:0] m_pend;
    logic [1:0] m_mid;
    logic [1:0] m_rr;
    logic [8:0] m_bus;
    bit         m_valid = 1'b0;

    function automatic int pick(input logic [3:0] req, input logic [1:0] rr);
        for (int k = 0; k < 4; k++) begin
            if (req[(int'(rr) + k) % 4]) return (int'(rr) + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (cpurst) begin
            m_phase <= 0;
            m_pend  <= 4'b0000;
            m_mid   <= 2'd0;
            m_rr    <= 2'd0;
            m_bus   <= 9'd0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                0: if (pick(piu_bar_req, m_rr) >= 0) begin
                    m_mid   <= 2'(pick(piu_bar_req, m_rr));
                    m_bus   <= piu_bar_req_bus[9*pick(piu_bar_req, m_rr) +: 9];
                    m_pend  <= 4'b1111;
                    m_phase <= 1;
                end
                1: begin
                    m_pend <= m_pend & ~tgt_bar_grant;
                    if ((m_pend & ~tgt_bar_grant) == 4'b0000) m_phase <= 2;
                end
                default: begin
                    m_rr    <= 2'((int'(m_mid) + 1) % 4);
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model bar_busy", bar_busy, m_phase != 0);
            check("model tgt_bar_req", tgt_bar_req, (m_phase == 1) ? m_pend : 4'b0000);
            check("model tgt_bar_mid", tgt_bar_mid, (m_phase != 0) ? {1'b0, m_mid} : 3'd0);
            check("model tgt_bar_req_bus", tgt_bar_req_bus, (m_phase != 0) ? m_bus : 9'd0);
            check("model piu_bar_done", piu_bar_done, (m_phase == 2) ? (4'b0001 << m_mid) : 4'b0000);
`ifndef CT_CIU_BAR_TMO_EN
            check("model bar_tmo_err", bar_tmo_err, 1'b0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int done_q[$];
    int cyc_q[$];

    initial begin
        cpurst          = 1'b1;
        piu_bar_req     = 4'b0000;
        piu_bar_req_bus = {9'h0AA, 9'h1A5, 9'h033, 9'h111};
        tgt_bar_grant   = 4'b0000;
        tick();
        tick();
        cpurst = 1'b0;
        check("reset busy", bar_busy, 1'b0);
        check("reset outputs", {tgt_bar_req, tgt_bar_mid, tgt_bar_req_bus, piu_bar_done, bar_tmo_err}, '0);

        // Single barrier from PIU2, all grants in cycle 1
        piu_bar_req = 4'b0100;
        tick();
        check("single mid", tgt_bar_mid, 3'd2);
        check("single bus", tgt_bar_req_bus, 9'h1A5);
        check("single req c1", tgt_bar_req, 4'b1111);
        tgt_bar_grant = 4'b1111;
        tick();
        tgt_bar_grant = 4'b0000;
        piu_bar_req   = 4'b0000;
        check("single done c2", piu_bar_done, 4'b0100);
        check("single req c2", tgt_bar_req, 4'b0000);
        tick();
        check("single done c3", piu_bar_done, 4'b0000);
        check("single idle c3", bar_busy, 1'b0);

        // Staggered grants from PIU1, with a duplicate snb0 grant in cycle 2
        piu_bar_req = 4'b0010;
        tick();
        check("stag req c1", tgt_bar_req, 4'b1111);
        tgt_bar_grant = 4'b0001;
        tick();
        check("stag req c2", tgt_bar_req, 4'b1110);
        tgt_bar_grant = 4'b0001;
        tick();
        check("stag req c3", tgt_bar_req, 4'b1110);
        tgt_bar_grant = 4'b1000;
        tick();
        check("stag req c4", tgt_bar_req, 4'b0110);
        tgt_bar_grant = 4'b0000;
        tick();
        check("stag req c5", tgt_bar_req, 4'b0110);
        tgt_bar_grant = 4'b0110;
        tick();
        check("stag done c6", piu_bar_done, 4'b0010);
        tgt_bar_grant = 4'b0000;
        piu_bar_req   = 4'b0000;
        tick();
        check("stag idle c7", bar_busy, 1'b0);

        // Stray grants in IDLE
        tgt_bar_grant = 4'b1111;
        tick();
        check("stray busy", bar_busy, 1'b0);
        check("stray req", tgt_bar_req, 4'b0000);
        tgt_bar_grant = 4'b0000;
        tick();

        // Reset while broadcasting with snb0+snb1 granted
        piu_bar_req = 4'b1000;
        tick();
        check("rst mid", tgt_bar_mid, 3'd3);
        tgt_bar_grant = 4'b0011;
        tick();
        check("rst req before", tgt_bar_req, 4'b1100);
        tgt_bar_grant = 4'b0000;
        cpurst        = 1'b1;
        tick();
        cpurst = 1'b0;
        check("rst outputs", {bar_busy, tgt_bar_req, tgt_bar_mid, tgt_bar_req_bus, piu_bar_done}, '0);

        // Round-robin fairness with all PIUs requesting and immediate grants
        piu_bar_req   = 4'b1111;
        tgt_bar_grant = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (piu_bar_done != 4'b0000) begin
                for (int b = 0; b < 4; b++) if (piu_bar_done[b]) done_q.push_back(b);
                cyc_q.push_back(k);
                piu_bar_req = 4'b1111 & ~piu_bar_done;
            end else begin
                piu_bar_req = 4'b1111;
            end
        end
        check("rr done count", done_q.size() >= 5, 1'b1);
        if (done_q.size() >= 5) begin
            check("rr order 0", done_q[0], 0);
            check("rr order 1", done_q[1], 1);
            check("rr order 2", done_q[2], 2);
            check("rr order 3", done_q[3], 3);
            check("rr order 4", done_q[4], 0);
            for (int j = 1; j < 5; j++) check("rr spacing", cyc_q[j] - cyc_q[j-1], 3);
        end
        piu_bar_req   = 4'b0000;
        tgt_bar_grant = 4'b0000;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
